// File: rtl/dual_input_debouncer.sv
// Two independent raw-input conditioning channels. Each channel synchronizes its input,
// qualifies every level change with a counter, and emits the clean level plus edge pulses.

module debounce_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_d, rise_d, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // A return of s to the stable level during a check abandons it; the count restarts from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = CHK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_LO;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = CHK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

module dual_input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_out,
    output logic b_out,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);
    debounce_channel #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
    ) u_ch_a (
        .clk(clk), .reset_n(reset_n), .raw(a_raw),
        .level(a_out), .rise(a_rise), .fall(a_fall)
    );

    debounce_channel #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
    ) u_ch_b (
        .clk(clk), .reset_n(reset_n), .raw(b_raw),
        .level(b_out), .rise(b_rise), .fall(b_fall)
    );
endmodule

// File: tb/tb_dual_input_debouncer.sv
// Directed bench for dual_input_debouncer: default build plus a 3-stage, 1-cycle build.
// Output vectors are packed as {a_out,a_rise,a_fall,b_out,b_rise,b_fall}.

module tb_dual_input_debouncer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic a_raw = 1'b0, b_raw = 1'b0;
    logic f_a_raw = 1'b0, f_b_raw = 1'b0;
    logic a_out, b_out, a_rise, a_fall, b_rise, b_fall;
    logic f_a_out, f_b_out, f_a_rise, f_a_fall, f_b_rise, f_b_fall;
    logic [5:0] v, fv;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dual_input_debouncer u_dut (
        .clk(clk), .reset_n(reset_n), .a_raw(a_raw), .b_raw(b_raw),
        .a_out(a_out), .b_out(b_out), .a_rise(a_rise), .a_fall(a_fall),
        .b_rise(b_rise), .b_fall(b_fall)
    );

    dual_input_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(2)) u_fast (
        .clk(clk), .reset_n(reset_n), .a_raw(f_a_raw), .b_raw(f_b_raw),
        .a_out(f_a_out), .b_out(f_b_out), .a_rise(f_a_rise), .a_fall(f_a_fall),
        .b_rise(f_b_rise), .b_fall(f_b_fall)
    );

    assign v  = {a_out, a_rise, a_fall, b_out, b_rise, b_fall};
    assign fv = {f_a_out, f_a_rise, f_a_fall, f_b_out, f_b_rise, f_b_fall};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Advance n edges, checking the default build after each one.
    task automatic hold(input int n, input string tag, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, v, exp);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("reset_dflt", v, 6'b000_000);
        chk("reset_fast", fv, 6'b000_000);
        reset_n = 1'b1;
        hold(3, "idle", 6'b000_000);

        // Clean rise on A: out appears after edge 18, not 17
        a_raw = 1'b1;
        hold(17, "a_rise_wait", 6'b000_000);
        hold(1, "a_rise_edge18", 6'b110_000);
        hold(2, "a_rise_after", 6'b100_000);

        // Bring B high, then drop both on the same edge
        b_raw = 1'b1;
        hold(17, "b_rise_wait", 6'b100_000);
        hold(1, "b_rise_edge18", 6'b100_110);
        hold(1, "b_rise_after", 6'b100_100);
        a_raw = 1'b0;
        b_raw = 1'b0;
        hold(17, "both_fall_wait", 6'b100_100);
        hold(1, "both_fall_edge18", 6'b001_001);
        hold(2, "both_fall_after", 6'b000_000);

        // Bounce on A: 15 high, 1 low, then high; last capture at edge 17 -> out at edge 34
        a_raw = 1'b1;
        hold(15, "bounce_burst", 6'b000_000);
        a_raw = 1'b0;
        hold(1, "bounce_low", 6'b000_000);
        a_raw = 1'b1;
        hold(17, "bounce_requal", 6'b000_000);
        hold(1, "bounce_edge34", 6'b110_000);
        hold(2, "bounce_after", 6'b100_000);

        // Reset mid-qualification of B, with both raws high
        b_raw = 1'b1;
        hold(10, "b_qualifying", 6'b100_000);
        reset_n = 1'b0;
        #1;
        chk("async_reset", v, 6'b000_000);
        hold(2, "in_reset", 6'b000_000);
        reset_n = 1'b1;
        hold(17, "post_reset_wait", 6'b000_000);
        hold(1, "post_reset_edge18", 6'b110_110);
        hold(1, "post_reset_after", 6'b100_100);

        // Fast build: one-cycle raw pulse -> out high one cycle after edge 4
        f_a_raw = 1'b1;
        step();
        chk("fast_e1", fv, 6'b000_000);
        f_a_raw = 1'b0;
        step();
        chk("fast_e2", fv, 6'b000_000);
        step();
        chk("fast_e3", fv, 6'b000_000);
        step();
        chk("fast_e4_rise", fv, 6'b110_000);
        step();
        chk("fast_e5_fall", fv, 6'b001_000);
        step();
        chk("fast_e6_idle", fv, 6'b000_000);
        chk("dflt_undisturbed", v, 6'b100_100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dual_input_debouncer.md
Name: dual_input_debouncer

Overview:
- Two-channel input conditioning stage; drives the a_in/b_in inputs of the registered NAND flip-flop stage.
- Each raw, asynchronous, possibly bouncing input passes through a synchronizer and then a counter-based debounce state machine.
- Produces clean level outputs plus one-cycle rise/fall pulses per channel.
- The two channels are fully independent and identical.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per channel; legal range >=2.
- DEBOUNCE_CYCLES, 16, consecutive synchronized samples of the new level required before the output changes; legal range >=1.
- CNT_W, 5, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_raw  in  1  channel A raw input, asynchronous to clk.
- b_raw  in  1  channel B raw input, asynchronous to clk.
- a_out  out  1  channel A debounced level (registered).
- b_out  out  1  channel B debounced level (registered).
- a_rise  out  1  one-cycle pulse, a_out went 0->1.
- a_fall  out  1  one-cycle pulse, a_out went 1->0.
- b_rise  out  1  one-cycle pulse, b_out went 0->1.
- b_fall  out  1  one-cycle pulse, b_out went 1->0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All synchronizer flops 0, counters 0, both FSMs in STABLE_LO.
  - a_out, b_out, and all rise/fall pulses 0.
- Synchronizer: shift chain of SYNC_STAGES flops; s = last flop output. Only s is used by the FSM.
- FSM states per channel: STABLE_LO (out=0), CHK_HI, STABLE_HI (out=1), CHK_LO.
- STABLE_LO, s=0: stay.
- STABLE_LO, s=1:
  - If DEBOUNCE_CYCLES==1: go to STABLE_HI, out<=1, rise<=1.
  - Otherwise: go to CHK_HI, cnt<=1.
- CHK_HI, s=0: glitch rejected; return to STABLE_LO, cnt<=0; out unchanged, no pulse.
- CHK_HI, s=1, cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, out<=1, rise<=1, cnt<=0.
- CHK_HI, s=1, otherwise: cnt<=cnt+1.
- STABLE_HI and CHK_LO mirror STABLE_LO and CHK_HI with levels inverted; completion asserts fall.
- Rise/fall pulses:
  - Registered; high for exactly one cycle, coincident with the first cycle of the new out value.
  - Otherwise 0.
  - Rise and fall are never both high on one channel.
- Latency: a clean raw level change first captured at edge 1 appears on out after edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults: edge 18.
- Bounce handling:
  - Any return of s to the current stable level during CHK restarts qualification from zero.
  - Pulses shorter than DEBOUNCE_CYCLES synchronized cycles never reach out.
- Counter: never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Simultaneous events:
  - Channels A and B may complete in the same cycle; both outputs and both pulses update together.
  - There is no cross-channel interaction.
- Reset mid-operation: an in-progress CHK is abandoned; outputs return to 0 immediately on reset_n assertion, with no pulse generated.
- Reset release with raw=1: the channel qualifies the high level normally. out rises after the full latency and a rise pulse is issued.
- All outputs are driven directly from flops; no combinational path from input to output.

Test Plan:
- Reset behaviour: assert reset_n=0 with a_raw=b_raw=1 mid-run -> all outputs 0 immediately. Release with raw held 1, defaults -> a_out=b_out=1 and a_rise=b_rise=1 for one cycle after the 18th edge.
- Clean transition: a_raw 0->1 held, defaults -> a_out rises after edge 18 (not edge 17); a_rise high exactly one cycle; b channel unchanged.
- Bounce rejection: a_raw high 15 cycles, low 1 cycle, then high for good -> a_out stays 0 through the first burst. a_out rises 16 synchronized cycles after the final low-to-high; no a_fall ever asserted.
- Falling edge and independence: from a_out=b_out=1, drop both raws on the same edge -> a_fall and b_fall assert in the same cycle, after edge 18.
- DEBOUNCE_CYCLES=1, SYNC_STAGES=3: single-cycle raw pulse -> out high for one cycle after edge 4, then low. rise and fall pulses land on consecutive cycles.
- Reset mid-qualification: raw high for 10 cycles, then reset_n low for 2 cycles, then released with raw still high -> no pulse during reset. a_out rises 18 edges after release.
